// File: rtl/seq_mul_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_unit_pkg
// Purpose  : Shared types and constants for the sequential multiplier:
//            FSM state encoding, word/step sizes, write-back select codes and
//            the product overflow helper.
// Ports    : (package - none)
// Config   : SEQ_MUL_SIGNED_EN (consumed by seq_mul_unit, not used here)
// Revision : 1.0 - initial release
// ============================================================================
package seq_mul_unit_pkg;

  localparam int WORD_W    = 16;
  localparam int MUL_STEPS = 16;
  // Working register: 16-bit high half plus one guard/carry bit, plus low half.
  localparam int ACC_W     = 2 * WORD_W + 1;
  localparam int CNT_W     = 4;

  localparam logic WR_SEL_LO = 1'b0;
  localparam logic WR_SEL_HI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WB_LO = 2'd2,
    ST_WB_HI = 2'd3
  } state_t;

  // Overflow when the high word is not the extension of product bit 15:
  // zero-extension for unsigned, sign-extension for signed.
  function automatic logic calc_overflow(input logic [2*WORD_W-1:0] prod,
                                         input logic               is_signed);
    logic [WORD_W-1:0] ext;
    ext = {WORD_W{is_signed & prod[WORD_W-1]}};
    return (prod[2*WORD_W-1:WORD_W] != ext);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_unit_mul_step.sv
`default_nettype none
// ============================================================================
// Module   : mul_step
// Purpose  : One combinational multiply iteration: conditionally add or
//            subtract the multiplicand into the high part of the working
//            register, then shift the whole register right by one.
// Ports    : i_acc         - current 33-bit working register
//            i_mcand       - 16-bit multiplicand
//            i_bit_cur     - multiplier bit being processed (LSB first)
//            i_bit_prev    - previously processed multiplier bit (Booth)
//            i_signed_mode - 1: radix-2 Booth, 0: unsigned shift-add
//            o_acc_next    - working register after this iteration
// Revision : 1.0 - initial release
// ============================================================================
module mul_step
  import seq_mul_unit_pkg::*;
(
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [WORD_W-1:0] i_mcand,
  input  logic              i_bit_cur,
  input  logic              i_bit_prev,
  input  logic              i_signed_mode,
  output logic [ACC_W-1:0]  o_acc_next
);

  logic [WORD_W:0] w_mcand_ext;
  logic [WORD_W:0] w_hi;
  logic [WORD_W:0] w_sum;
  logic            w_shift_in;

  assign w_mcand_ext = {i_signed_mode & i_mcand[WORD_W-1], i_mcand};
  assign w_hi        = i_acc[ACC_W-1:WORD_W];

  always_comb begin
    w_sum = w_hi;
    if (i_signed_mode) begin
      // Booth recoding: 01 -> +M, 10 -> -M, 00/11 -> no change.
      case ({i_bit_cur, i_bit_prev})
        2'b01:   w_sum = w_hi + w_mcand_ext;
        2'b10:   w_sum = w_hi - w_mcand_ext;
        default: w_sum = w_hi;
      endcase
    end else if (i_bit_cur) begin
      // Unsigned: the 17-bit sum keeps the carry, which lands in bit 31.
      w_sum = w_hi + w_mcand_ext;
    end
  end

  // Arithmetic shift in signed mode; zero-fill in unsigned mode.
  assign w_shift_in = i_signed_mode & w_sum[WORD_W];
  assign o_acc_next = {w_shift_in, w_sum, i_acc[WORD_W-1:1]};

endmodule
`default_nettype wire

// File: rtl/seq_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_unit
// Purpose  : 16x16 -> 32 sequential multiplier, one multiplier bit per cycle,
//            writing the product back as two words (low, then high) through
//            a single register-file style write port.
// Ports    : clk      - clock, rising edge
//            rst_b    - asynchronous active-low reset
//            start    - request, sampled only in IDLE
//            op_a     - multiplicand, captured on accepted start
//            op_b     - multiplier, captured on accepted start
//            signed_op- (SEQ_MUL_SIGNED_EN only) 1 = Booth signed multiply
//            busy     - operation in progress (RUN / WB_LO / WB_HI)
//            wr_en    - write strobe to destination register
//            wr_sel   - 0 = low-word register, 1 = high-word register
//            wr_data  - write-back word
//            done     - pulse with the high-word write
//            flag_z   - product was zero
//            flag_v   - high word is not the extension of bit 15
// Config   : SEQ_MUL_SIGNED_EN - adds signed_op and Booth signed multiply
// Latency  : done in the 18th cycle after the accepting edge; a new start is
//            accepted in the IDLE cycle following WB_HI (19-cycle period).
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_unit
  import seq_mul_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic              signed_op,
`endif
  output logic              busy,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [WORD_W-1:0] wr_data,
  output logic              done,
  output logic              flag_z,
  output logic              flag_v
);

  state_t              r_state;
  state_t              w_state_next;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_next;
  logic [WORD_W-1:0]   r_mcand;
  logic [WORD_W-1:0]   r_mplr;
  logic                r_prev;
  logic [CNT_W-1:0]    r_count;
  logic                r_flag_z;
  logic                r_flag_v;
  logic                w_signed_mode;
  logic                w_accept;
  logic [2*WORD_W-1:0] w_product;

`ifdef SEQ_MUL_SIGNED_EN
  logic r_signed;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_signed <= signed_op;
    end
  end

  assign w_signed_mode = r_signed;
`else
  assign w_signed_mode = 1'b0;
`endif

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_product = r_acc[2*WORD_W-1:0];

  mul_step u_mul_step (
    .i_acc         (r_acc),
    .i_mcand       (r_mcand),
    .i_bit_cur     (r_mplr[0]),
    .i_bit_prev    (r_prev),
    .i_signed_mode (w_signed_mode),
    .o_acc_next    (w_acc_next)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs. Outputs are pure decodes of the state so that
  // reset clears them immediately and nothing leaks outside write-back.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    wr_en        = 1'b0;
    wr_sel       = WR_SEL_LO;
    wr_data      = '0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_count == '0) begin
          w_state_next = ST_WB_LO;
        end
      end
      ST_WB_LO: begin
        wr_en        = 1'b1;
        wr_sel       = WR_SEL_LO;
        wr_data      = w_product[WORD_W-1:0];
        w_state_next = ST_WB_HI;
      end
      ST_WB_HI: begin
        wr_en        = 1'b1;
        wr_sel       = WR_SEL_HI;
        wr_data      = w_product[2*WORD_W-1:WORD_W];
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. Operands only load on acceptance, so a start seen while busy
  // cannot disturb an operation in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_prev  <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_mcand <= op_a;
      r_mplr  <= op_b;
      r_prev  <= 1'b0;
      r_count <= CNT_W'(MUL_STEPS - 1);
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_acc_next;
      r_mplr  <= {1'b0, r_mplr[WORD_W-1:1]};
      r_prev  <= r_mplr[0];
      r_count <= r_count - 1'b1;
    end
  end

  // Flags load on entry to WB_HI so they are valid alongside done and hold
  // until the next product's WB_HI.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (r_state == ST_WB_LO) begin
      r_flag_z <= (w_product == '0);
      r_flag_v <= calc_overflow(w_product, w_signed_mode);
    end
  end

  assign flag_z = r_flag_z;
  assign flag_v = r_flag_v;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mul_unit
// Purpose  : Self-checking bench for seq_mul_unit. The driver pushes the
//            hand-computed product of each accepted request into a queue; a
//            negedge monitor pops it when the write-back words appear.
// Config   : SEQ_MUL_SIGNED_EN enables the signed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        s_op;
  logic        busy;
  logic        wr_en;
  logic        wr_sel;
  logic [15:0] wr_data;
  logic        done;
  logic        flag_z;
  logic        flag_v;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        z;
    logic        v;
  } exp_t;

  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   busy_cnt = 0;
  int   last_done_cyc = -1;
  logic burst = 1'b0;
  logic got_lo = 1'b0;
  logic flags_pending = 1'b0;
  logic pend_z, pend_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_unit dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_op (s_op),
`endif
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .done      (done),
    .flag_z    (flag_z),
    .flag_v    (flag_v)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_b) begin
      busy_cnt      = 0;
      got_lo        = 1'b0;
      flags_pending = 1'b0;
    end else begin
      if (flags_pending) begin
        chk("flag_z", {31'b0, flag_z}, {31'b0, pend_z});
        chk("flag_v", {31'b0, flag_v}, {31'b0, pend_v});
        flags_pending = 1'b0;
      end
      busy_cnt = busy ? busy_cnt + 1 : 0;
      if (!wr_en) begin
        chk("quiet_outputs", {15'b0, done, wr_data}, 32'h0);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=sel %0d data 0x%0h required=no write (t=%0t)",
                 wr_sel, wr_data, $time);
      end else if (wr_sel == 1'b0) begin
        chk("wb_lo_data", {16'b0, wr_data}, {16'b0, exp_q[0].lo});
        chk("wb_lo_done", {31'b0, done}, 32'h0);
        got_lo = 1'b1;
      end else begin
        chk("order_lo_then_hi", {31'b0, got_lo}, 32'h1);
        chk("wb_hi_data", {16'b0, wr_data}, {16'b0, exp_q[0].hi});
        chk("wb_hi_done", {31'b0, done}, 32'h1);
        // RUN(16) + WB_LO + WB_HI: done lands in the 18th busy cycle.
        chk("latency_busy_cycles", busy_cnt, 32'd18);
        if (burst && last_done_cyc >= 0) begin
          chk("burst_period", cyc - last_done_cyc, 32'd19);
        end
        last_done_cyc = cyc;
        pend_z        = exp_q[0].z;
        pend_v        = exp_q[0].v;
        flags_pending = 1'b1;
        void'(exp_q.pop_front());
        got_lo = 1'b0;
        done_count++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic push_exp(input logic [15:0] lo, input logic [15:0] hi,
                          input logic z, input logic v);
    exp_t e;
    e.lo = lo; e.hi = hi; e.z = z; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    s_op  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int tgt;
    int n;
    tgt = done_count + 1;
    n   = 0;
    while (done_count < tgt && n < 60) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (done_count < tgt) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no done required=done within 60 cycles", name);
    end
  endtask

  task automatic mul(input string name, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input logic [15:0] lo, input logic [15:0] hi,
                     input logic z, input logic v);
    push_exp(lo, hi, z, v);
    issue(a, b, s);
    wait_done(name);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int wr_seen;
    rst_b = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    s_op  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'b0, busy, wr_en, wr_sel, |wr_data, done, flag_z, flag_v}, 32'h0);
    rst_b = 1'b1;

    // Unsigned directed vectors
    mul("u_3x5",       16'h0003, 16'h0005, 1'b0, 16'h000F, 16'h0000, 1'b0, 1'b0);
    mul("u_ffff_sq",   16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 1'b0, 1'b1);
    mul("u_1234x0",    16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    mul("u_0x1234",    16'h0000, 16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    mul("u_8000x2",    16'h8000, 16'h0002, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1);

`ifdef SEQ_MUL_SIGNED_EN
    mul("s_m2x3",      16'hFFFE, 16'h0003, 1'b1, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0);
    mul("s_min_sq",    16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h4000, 1'b0, 1'b1);
    mul("s_m1xm1",     16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    mul("u_ffff_sq_b", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 1'b0, 1'b1);
`endif

    // start pulsed in RUN cycle 5 with other operands must be ignored:
    // 0x00FF * 0x0101 = 0x0000FFFF (7 * 9 would give 0x003F).
    push_exp(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    issue(16'h00FF, 16'h0101, 1'b0);
    repeat (5) @(negedge clk);
    op_a  = 16'h0007;
    op_b  = 16'h0009;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignored_start");

    // Reset in RUN cycle 8 aborts with no write-back afterwards.
    issue(16'h0002, 16'h0003, 1'b0);
    repeat (8) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("abort_busy",  {31'b0, busy},  32'h0);
    chk("abort_wr_en", {31'b0, wr_en}, 32'h0);
    repeat (2) @(negedge clk);
    rst_b   = 1'b1;
    wr_seen = 0;
    repeat (30) begin
      @(negedge clk);
      #2;
      if (wr_en) wr_seen++;
    end
    chk("no_write_after_abort", wr_seen, 32'h0);

    // start already high at reset release is accepted on the first edge.
    @(negedge clk);
    rst_b = 1'b0;
    op_a  = 16'h0003;
    op_b  = 16'h0005;
    start = 1'b1;
    push_exp(16'h000F, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("first_edge_accept", {31'b0, busy}, 32'h1);
    wait_done("after_release");

    // start held high: a product every 19 cycles. 0xABCD * 2 = 0x0001579A.
    burst         = 1'b1;
    last_done_cyc = -1;
    repeat (3) push_exp(16'h579A, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    op_a  = 16'hABCD;
    op_b  = 16'h0002;
    start = 1'b1;
    for (int k = 0; k < 3; k++) wait_done("burst");
    start = 1'b0;
    repeat (25) @(negedge clk);
    burst = 1'b0;
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
